// File: rtl/oqpsk_pulse_shaper.sv
// O-QPSK half-sine pulse shaper: serial chips in, shaped I/Q baseband samples out.
// Even chips drive I and odd chips drive Q, with Q offset by one chip period.
// Each chip period is 4 samples, so every half-sine pulse spans 8 samples.
// Both ports use a valid/ready handshake. A single-entry buffer decouples chip arrival
// from the chip-boundary loads.
module oqpsk_pulse_shaper #(
  parameter int unsigned DATA_W = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              chip_in_i,
  input  logic              chip_valid_i,
  output logic              chip_ready_o,
  output logic [DATA_W-1:0] i_out_o,
  output logic [DATA_W-1:0] q_out_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o
);

  localparam int RomW = DATA_W - 1;

  // Quarter-wave magnitudes round((2^(w-1)-1)*sin(pi*k/8)) for k=0..4; the other half
  // mirrors around k=4. Widths outside 5..8 fall back to the 5-bit table.
  function automatic int rom_val(input int w, input int k);
    int q;
    int v;
    q = (k <= 4) ? k : 8 - k;
    v = 0;
    case (w)
      6: begin
        case (q)
          1: v = 12;
          2: v = 22;
          3: v = 29;
          4: v = 31;
          default: v = 0;
        endcase
      end
      7: begin
        case (q)
          1: v = 24;
          2: v = 45;
          3: v = 58;
          4: v = 63;
          default: v = 0;
        endcase
      end
      8: begin
        case (q)
          1: v = 49;
          2: v = 90;
          3: v = 117;
          4: v = 127;
          default: v = 0;
        endcase
      end
      default: begin
        case (q)
          1: v = 6;
          2: v = 11;
          3: v = 14;
          4: v = 15;
          default: v = 0;
        endcase
      end
    endcase
    return v;
  endfunction

  // Pack the eight unsigned magnitudes into one constant vector at elaboration.
  function automatic logic [8*RomW-1:0] build_rom();
    logic [8*RomW-1:0] t;
    t = '0;
    for (int k = 0; k < 8; k++) begin
      t[k*RomW +: RomW] = RomW'(rom_val(int'(DATA_W), k));
    end
    return t;
  endfunction

  localparam logic [8*RomW-1:0] RomTable = build_rom();

  function automatic logic [RomW-1:0] rom_at(input logic [2:0] p);
    return RomTable[int'(p)*RomW +: RomW];
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        phase_q, phase_d;
  logic              i_act_q, i_act_d;
  logic              q_act_q, q_act_d;
  logic              i_chip_q, i_chip_d;
  logic              q_chip_q, q_chip_d;
  logic              buf_full_q, buf_full_d;
  logic              buf_chip_q, buf_chip_d;
  logic [DATA_W-1:0] i_out_q, i_out_d;
  logic [DATA_W-1:0] q_out_q, q_out_d;
  logic              out_valid_q, out_valid_d;

  logic              chip_ready;
  logic              accept;
  logic              emit;
  logic              load;
  logic [2:0]        phase_nxt;
  logic [DATA_W-1:0] i_mag;
  logic [DATA_W-1:0] q_mag;

  // Handshake qualifiers and the signed-magnitude sample for each rail.
  always_comb begin
    chip_ready = !buf_full_q && (state_q != StDrain) && !reset_i;
    accept     = chip_valid_i && chip_ready;
    emit       = ((state_q == StRun) || (state_q == StDrain)) && (!out_valid_q || out_ready_i);
    phase_nxt  = phase_q + 3'd1;
    i_mag      = {1'b0, rom_at(phase_q)};
    // Q runs half a pulse behind I, i.e. four samples of phase offset.
    q_mag      = {1'b0, rom_at(phase_q + 3'd4)};
  end

  // Next-state: chip buffer, FSM, phase counter and output sample register.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    i_act_d     = i_act_q;
    q_act_d     = q_act_q;
    i_chip_d    = i_chip_q;
    q_chip_d    = q_chip_q;
    buf_full_d  = buf_full_q;
    buf_chip_d  = buf_chip_q;
    i_out_d     = i_out_q;
    q_out_d     = q_out_q;
    out_valid_d = out_valid_q;
    load        = 1'b0;

    // Accept and load are mutually exclusive: accept needs an empty buffer, load a full one.
    if (accept) begin
      buf_full_d = 1'b1;
      buf_chip_d = chip_in_i;
    end

    unique case (state_q)
      StIdle: begin
        if (buf_full_q) begin
          load     = 1'b1;
          i_chip_d = buf_chip_q;
          i_act_d  = 1'b1;
          q_act_d  = 1'b0;
          phase_d  = 3'd0;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (emit) begin
          phase_d = phase_nxt;
          if (phase_nxt == 3'd4) begin
            if (buf_full_q) begin
              load     = 1'b1;
              q_chip_d = buf_chip_q;
              q_act_d  = 1'b1;
            end else begin
              q_act_d = 1'b0;
              state_d = StDrain;
            end
          end else if (phase_nxt == 3'd0) begin
            if (buf_full_q) begin
              load     = 1'b1;
              i_chip_d = buf_chip_q;
              i_act_d  = 1'b1;
            end else begin
              i_act_d = 1'b0;
              state_d = StDrain;
            end
          end
        end
      end
      StDrain: begin
        // The starved rail is already off; the next boundary finishes the other pulse.
        if (emit) begin
          phase_d = phase_nxt;
          if ((phase_nxt == 3'd0) || (phase_nxt == 3'd4)) begin
            i_act_d = 1'b0;
            q_act_d = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      buf_full_d = 1'b0;
    end

    if (emit) begin
      i_out_d     = i_act_q ? (i_chip_q ? i_mag : -i_mag) : '0;
      q_out_d     = q_act_q ? (q_chip_q ? q_mag : -q_mag) : '0;
      out_valid_d = 1'b1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      phase_q     <= 3'd0;
      i_act_q     <= 1'b0;
      q_act_q     <= 1'b0;
      i_chip_q    <= 1'b0;
      q_chip_q    <= 1'b0;
      buf_full_q  <= 1'b0;
      buf_chip_q  <= 1'b0;
      i_out_q     <= '0;
      q_out_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      i_act_q     <= i_act_d;
      q_act_q     <= q_act_d;
      i_chip_q    <= i_chip_d;
      q_chip_q    <= q_chip_d;
      buf_full_q  <= buf_full_d;
      buf_chip_q  <= buf_chip_d;
      i_out_q     <= i_out_d;
      q_out_q     <= q_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign chip_ready_o = chip_ready;
  assign i_out_o      = i_out_q;
  assign q_out_o      = q_out_q;
  assign out_valid_o  = out_valid_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_oqpsk_pulse_shaper.sv
// Directed bench for oqpsk_pulse_shaper with a sample scoreboard.
module tb_oqpsk_pulse_shaper;

  localparam int DW = 5;

  logic                 clk;
  logic                 reset_i;
  logic                 chip_in;
  logic                 chip_valid;
  logic                 chip_ready;
  logic signed [DW-1:0] i_out;
  logic signed [DW-1:0] q_out;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;

  int checks;
  int failures;

  bit chip_q[$];
  int exp_i[$];
  int exp_q[$];
  int rom[8] = '{0, 6, 11, 14, 15, 14, 11, 6};

  oqpsk_pulse_shaper #(.DATA_W(DW)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .chip_in_i    (chip_in),
    .chip_valid_i (chip_valid),
    .chip_ready_o (chip_ready),
    .i_out_o      (i_out),
    .q_out_o      (q_out),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Reference: chip k occupies samples 4k..4k+7 on rail k%2; N chips give 4*(N+1) samples.
  task automatic model_burst(input int first, input int n);
    for (int s = 0; s < 4 * (n + 1); s++) begin
      int iv;
      int qv;
      iv = 0;
      qv = 0;
      for (int k = 0; k < n; k++) begin
        if (s >= 4 * k && s < 4 * k + 8) begin
          int v;
          v = chip_q[first + k] ? rom[s - 4 * k] : -rom[s - 4 * k];
          if (k % 2 == 0) iv = v;
          else qv = v;
        end
      end
      exp_i.push_back(iv);
      exp_q.push_back(qv);
    end
  endtask

  // Drives chip_q as one or two bursts and scores every accepted sample.
  // split>0: first burst is chip_q[0:split-1]. hold_idx chip is withheld until hold_until
  // samples have arrived. bp!=0 toggles out_ready 1,0,0. reset_at>=0 resets after that many.
  task automatic run_burst(input string tag, input int split, input int hold_idx,
                           input int hold_until, input int bp, input int reset_at);
    int total;
    int sent;
    int recv;
    int cyc;
    bit stall_prev;
    bit acc_prev;
    logic signed [31:0] prev_i;
    logic signed [31:0] prev_q;
    exp_i.delete();
    exp_q.delete();
    if (split > 0) begin
      model_burst(0, split);
      model_burst(split, chip_q.size() - split);
    end else begin
      model_burst(0, chip_q.size());
    end
    total = exp_i.size();
    sent = 0;
    recv = 0;
    cyc = 0;
    stall_prev = 1'b0;
    acc_prev = 1'b0;
    prev_i = 0;
    prev_q = 0;
    while (recv < total && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (stall_prev) begin
        check({tag, "_hold_valid"}, out_valid, 1);
        check({tag, "_hold_i"}, i_out, prev_i);
        check({tag, "_hold_q"}, q_out, prev_q);
      end
      if (acc_prev) check({tag, "_ready_full"}, chip_ready, 0);
      if (reset_at >= 0 && recv == reset_at) begin
        reset_i = 1'b1;
        chip_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check({tag, "_rst_ready"}, chip_ready, 0);
        @(negedge clk);
        check({tag, "_rst_valid"}, out_valid, 0);
        check({tag, "_rst_busy"}, busy, 0);
        check({tag, "_rst_i"}, i_out, 0);
        check({tag, "_rst_q"}, q_out, 0);
        reset_i = 1'b0;
        #1;
        check({tag, "_rst_bufempty"}, chip_ready, 1);
        exp_i.delete();
        exp_q.delete();
        return;
      end
      out_ready = (bp != 0) ? (cyc % 3 == 1) : 1'b1;
      chip_valid = (sent < chip_q.size()) && !(sent == hold_idx && recv < hold_until);
      chip_in = chip_valid ? chip_q[sent] : 1'b0;
      #1;
      acc_prev = chip_valid && chip_ready;
      if (acc_prev) sent++;
      stall_prev = out_valid && !out_ready;
      prev_i = i_out;
      prev_q = q_out;
      if (out_valid && out_ready) begin
        check({tag, "_i"}, i_out, exp_i.pop_front());
        check({tag, "_q"}, q_out, exp_q.pop_front());
        recv++;
      end
    end
    if (recv < total) check({tag, "_timeout_samples"}, recv, total);
    chip_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check({tag, "_end_busy"}, busy, 0);
    check({tag, "_end_valid"}, out_valid, 0);
    check({tag, "_end_ready"}, chip_ready, 1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_i = 1'b1;
    chip_in = 1'b1;
    chip_valid = 1'b1;
    out_ready = 1'b1;

    // Reset held three cycles with a chip on offer.
    repeat (3) begin
      @(negedge clk);
      check("reset_ready", chip_ready, 0);
      check("reset_valid", out_valid, 0);
      check("reset_i", i_out, 0);
      check("reset_q", q_out, 0);
      check("reset_busy", busy, 0);
    end
    reset_i = 1'b0;
    chip_valid = 1'b0;

    chip_q = '{1'b1, 1'b0};
    run_burst("two_chip", 0, -1, 0, 0, -1);

    chip_q = '{1'b1, 1'b1, 1'b1, 1'b1};
    run_burst("b2b", 0, -1, 0, 0, -1);

    chip_q = '{1'b1, 1'b1, 1'b1, 1'b1};
    run_burst("backpressure", 0, -1, 0, 1, -1);

    // Fourth chip withheld until the burst is draining: 16 samples, then a fresh burst.
    chip_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    run_burst("underrun", 3, 3, 12, 0, -1);

    chip_q = '{1'b1, 1'b0};
    run_burst("midreset", 0, -1, 0, 0, 5);

    chip_q = '{1'b1, 1'b0};
    run_burst("post_reset", 0, -1, 0, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oqpsk_pulse_shaper.md
Name: oqpsk_pulse_shaper

Overview:
- Transmit-side counterpart of the IQ demodulator front end.
- Takes the serial Zigbee chip stream and produces half-sine-shaped O-QPSK baseband I/Q samples for the DAC path.
- Even chips go to I, odd chips go to Q; Q is offset by one chip period (Tc).
- 4 samples per chip, so each pulse spans 8 samples. Chips enter through a valid/ready port and samples leave through a valid/ready port.

Parameters:
- DATA_W, 5: signed sample width, legal range 5..8. ROM[k] = round((2^(DATA_W-1)-1)*sin(pi*k/8)), k=0..7, computed at elaboration. For DATA_W=5, ROM = 0,6,11,14,15,14,11,6.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- chip_in  in  1  chip value; 1 maps to +pulse, 0 maps to -pulse
- chip_valid  in  1  chip_in is valid
- chip_ready  out  1  block can accept a chip
- i_out  out  DATA_W  signed I sample
- q_out  out  DATA_W  signed Q sample
- out_valid  out  1  i_out/q_out are valid
- out_ready  in  1  downstream accepts the sample
- busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, phase=0, i_act=0, q_act=0, buf_full=0; i_out=0, q_out=0, out_valid=0; chip_ready=0 while reset is high.
- Chip buffer (1 entry):
  - chip_ready = !buf_full && state!=DRAIN && !reset.
  - chip_valid&&chip_ready at an edge stores chip_in and sets buf_full.
  - A consuming load clears buf_full.
  - A chip presented in the cycle of a boundary load is stored, not used at that load.
- Emit condition: emit = (state RUN or DRAIN) && (!out_valid || out_ready). Without emit, i_out, q_out and out_valid hold stable.
- On emit:
  - i_out = i_act ? ±ROM[phase] : 0
  - q_out = q_act ? ±ROM[(phase+4)%8] : 0
  - sign is taken from each rail's stored chip
  - out_valid = 1
  - phase = (phase+1)%8
- With no emit and out_ready=1, out_valid drops to 0.
- FSM:
  - IDLE: if buf_full, load the chip as the I chip: i_act=1, q_act=0, phase=0, go to RUN. out_valid rises after the 2nd edge following chip acceptance.
  - RUN, emit with next phase=4: if buf_full, load Q chip and set q_act=1; otherwise set q_act=0 and go to DRAIN.
  - RUN, emit with next phase=0: if buf_full, load I chip and set i_act=1; otherwise set i_act=0 and go to DRAIN.
  - DRAIN: keep emitting. At the next boundary (next phase 0 or 4) clear the other rail's act flag and go to IDLE. No all-zero trailing sample is emitted.
- Burst length: N chips produce exactly 4*(N+1) samples. Chip k (0-based) starts at sample 4k on rail k%2.
- Underrun: buffer empty at a boundary ends the burst. There is no resume mid-burst; a later chip starts a fresh burst beginning on I.
- Backpressure: out_ready low stalls phase, FSM and chip loads. The buffer may still fill.
- Synchronous reset mid-burst returns everything to reset values at the next edge and drops any buffered chip.
- Arithmetic: ROM is unsigned, DATA_W-1 bits. Negation is two's complement, so the range is ±(2^(DATA_W-1)-1) and there is no overflow.

Test Plan:
- Reset: hold reset for 3 cycles with chip_valid=1 -> chip_ready=0, out_valid=0, i_out=q_out=0, busy=0 throughout.
- Chips {1,0}, out_ready=1 -> 12 samples:
  - I = 0,6,11,14,15,14,11,6,0,0,0,0
  - Q = 0,0,0,0,0,-6,-11,-14,-15,-14,-11,-6
  - then busy=0, out_valid=0.
- Chips {1,1,1,1} supplied back-to-back -> 20 samples. I = 0,6,11,14,15,14,11,6 repeated, then a zero tail; Q delayed 4 samples. chip_ready low whenever the buffer holds an unconsumed chip.
- Backpressure: same burst with out_ready toggling 1,0,0,1,... -> identical sample sequence; values stable while out_ready=0; no sample lost or duplicated.
- Underrun: chips {0,1,0}, with the 4th chip withheld past sample 12 -> 16 samples total, burst ends in DRAIN. A later chip 1 starts a new burst whose first sample is I=0, Q=0 and whose second is I=+6.
- Reset asserted at sample 5 of a burst -> next edge out_valid=0, busy=0, buffer empty. A new burst afterwards matches the 2-chip reference sequence.
